// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (frame width, default bit period,
// receiver FSM states) used by the RX and TX sides.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: sync FIFO, registered head (rdata_o=0 when empty).
// Ports: push_i/wdata_i in, pop_i in, rdata_o/valid_o out, overrun_o pulse.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             overrun_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, head_d;
  logic             valid_q;
  logic             overrun_q;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign full    = count_q == (AW+1)'(DEPTH);
  assign pop_ok  = pop_i && valid_q;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    if (push_ok && !pop_ok)
      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok)
      count_d = count_q - 1'b1;
    head_d = '0;
    // new head is the byte being written when nothing else remains
    if (count_d != '0)
      head_d = (push_ok && rd_d == wr_q) ? wdata_i : mem_q[rd_d];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= push_ok ? wr_q + 1'b1 : wr_q;
      count_q   <= count_d;
      data_q    <= head_d;
      valid_q   <= count_d != '0;
      overrun_q <= push_i && !push_ok;
    end
  end

  assign rdata_o   = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, mid-bit sampling, FIFO-buffered valid/ready out.
// Ports: CLK, RST(async low), RXD in; DATA/VALID/READY; FRAME_ERR, OVERRUN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RXD,
  output logic [UART_DATA_BITS-1:0] DATA,
  output logic                      VALID,
  input  logic                      READY,
  output logic                      FRAME_ERR,
  output logic                      OVERRUN
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    MSB_IDX = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_q;
  logic                      rx_s_q;
  uart_state_e               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      push;
  logic                      bit_end;

  assign bit_end = cnt_q == LAST;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (!rx_s_q) state_d = S_START;
      S_START:
        if (cnt_q == HALF_M1)
          state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:
        if (bit_end && bit_idx_q == MSB_IDX)
          state_d = S_STOP;
      S_STOP:
        if (bit_end)
          state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK:
        if (rx_s_q) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (state_q == S_IDLE || state_d != state_q || bit_end)
      cnt_d = '0;
    unique case (1'b1)
      state_q == S_START: bit_idx_d = '0;
      state_q == S_DATA: begin
        if (bit_end) begin
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
        end
      end
      state_q == S_STOP: begin
        push        = bit_end && rx_s_q;
        frame_err_d = bit_end && !rx_s_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign FRAME_ERR = frame_err_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .push_i    (push),
    .wdata_i   (shift_q),
    .pop_i     (READY),
    .rdata_o   (DATA),
    .valid_o   (VALID),
    .overrun_o (OVERRUN)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Frames are driven bit-by-bit; outputs sampled 1 time unit after CLK rises.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  // RXD low -> VALID high: 2 sync + HALF + 9 bits + 1 register
  localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

  logic       CLK;
  logic       RST;
  logic       RXD;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cnt = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int ov_cyc = -1;
  logic v_prev = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RXD       (RXD),
    .DATA      (DATA),
    .VALID     (VALID),
    .READY     (READY),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (VALID && !v_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    v_prev = VALID;
    if (FRAME_ERR) fe_cnt++;
    if (OVERRUN) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop,
                      input int rdy_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    t0 = cyc;
    for (int k = 0; k < FRAME; k++) begin
      RXD   = fr[k / CPB];
      READY = (k == rdy_at);
      tick(1);
    end
    READY = 1'b0;
  endtask

  task automatic pop();
    READY = 1'b1;
    tick(1);
    READY = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    check({tag, "_valid"}, 32'(VALID), 32'd1);
    check({tag, "_data"}, 32'(DATA), 32'(b));
    pop();
  endtask

  initial begin
    int rc;
    int fe;
    int ov;
    logic [9:0] fr;

    RST   = 1'b0;
    RXD   = 1'b1;
    READY = 1'b0;
    tick(3);
    check("rst_data", 32'(DATA), 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_ferr", 32'(FRAME_ERR), 32'd0);
    check("rst_ovr", 32'(OVERRUN), 32'd0);
    RST = 1'b1;
    tick(4);

    // single byte, exact latency, hold, pop
    send(8'h55, 1'b1, -1);
    check("lat_55", 32'(rise_cyc - t0), 32'(LAT));
    check("v_55", 32'(VALID), 32'd1);
    check("d_55", 32'(DATA), 32'h55);
    tick(20);
    check("hold_v_55", 32'(VALID), 32'd1);
    check("hold_d_55", 32'(DATA), 32'h55);
    pop();
    check("pop_v_55", 32'(VALID), 32'd0);
    check("pop_d_55", 32'(DATA), 32'd0);
    tick(4);

    // 6-cycle glitch
    rc  = rise_cnt;
    fe  = fe_cnt;
    RXD = 1'b0;
    tick(6);
    RXD = 1'b1;
    tick(30);
    check("gl_norise", 32'(rise_cnt), 32'(rc));
    check("gl_noferr", 32'(fe_cnt), 32'(fe));
    check("gl_idle", 32'(dut.state_q), 32'(S_IDLE));
    send(8'hC3, 1'b1, -1);
    tick(2);
    expect_byte("gl_c3", 8'hC3);
    tick(4);

    // framing error then break
    rc = rise_cnt;
    fe = fe_cnt;
    send(8'hA3, 1'b0, -1);
    tick(3 * CPB);
    RXD = 1'b1;
    tick(30);
    check("fe_once", 32'(fe_cnt), 32'(fe + 1));
    check("fe_norise", 32'(rise_cnt), 32'(rc));
    check("fe_valid", 32'(VALID), 32'd0);
    send(8'h3C, 1'b1, -1);
    tick(2);
    expect_byte("fe_3c", 8'h3C);
    tick(4);

    // overrun on the fifth back-to-back byte
    ov = ov_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1);
    check("ov_once", 32'(ov_cnt), 32'(ov + 1));
    check("ov_time", 32'(ov_cyc - t0), 32'(LAT));
    tick(2);
    expect_byte("ov_01", 8'h01);
    expect_byte("ov_02", 8'h02);
    expect_byte("ov_03", 8'h03);
    expect_byte("ov_04", 8'h04);
    check("ov_empty", 32'(VALID), 32'd0);
    tick(4);

    // full FIFO, pop in the push cycle
    ov = ov_cnt;
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    send(8'h33, 1'b1, -1);
    send(8'h44, 1'b1, -1);
    send(8'h55, 1'b1, LAT - 1);
    check("pp_noovr", 32'(ov_cnt), 32'(ov));
    expect_byte("pp_22", 8'h22);
    expect_byte("pp_33", 8'h33);
    expect_byte("pp_44", 8'h44);
    expect_byte("pp_55", 8'h55);
    check("pp_empty", 32'(VALID), 32'd0);
    tick(4);

    // reset during data bit 4 with two bytes buffered
    send(8'h66, 1'b1, -1);
    send(8'h77, 1'b1, -1);
    tick(2);
    check("rm_v_pre", 32'(VALID), 32'd1);
    check("rm_d_pre", 32'(DATA), 32'h66);
    fr = {1'b1, 8'h99, 1'b0};
    for (int k = 0; k < 5 * CPB + 5; k++) begin
      RXD = fr[k / CPB];
      tick(1);
    end
    RST = 1'b0;
    #1;
    check("rm_valid", 32'(VALID), 32'd0);
    check("rm_data", 32'(DATA), 32'd0);
    check("rm_ferr", 32'(FRAME_ERR), 32'd0);
    check("rm_ovr", 32'(OVERRUN), 32'd0);
    check("rm_idle", 32'(dut.state_q), 32'(S_IDLE));
    RXD = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(5);
    check("rm_empty", 32'(VALID), 32'd0);
    send(8'hF0, 1'b1, -1);
    tick(2);
    expect_byte("rm_f0", 8'hF0);
    check("rm_end", 32'(VALID), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the SOC's `RXD` pin: 8 data bits, no parity, 1 stop bit (8N1), LSB first. It detects and validates the start bit, samples each bit at its midpoint and buffers received bytes in a small FIFO. Bytes are presented to the bus-side consumer through a valid/ready handshake. It is the receiving counterpart of the SOC's `TXD` transmitter and is driven by the same `CLK`/`RST`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: `CLK` cycles per bit (12 MHz / 115200). Legal values are even and ≥ 4. `HALF = CLKS_PER_BIT/2`.
- `FIFO_DEPTH`, default 4: receive buffer entries. Must be a power of 2, ≥ 2.

Ports:
- `CLK` in 1: single clock; all state is updated on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `RXD` in 1: asynchronous serial input; the line idles high.
- `DATA` out 8: byte at the FIFO head; 0 when empty.
- `VALID` out 1: FIFO non-empty.
- `READY` in 1: consumer accepts `DATA`. A pop occurs on `VALID && READY`.
- `FRAME_ERR` out 1: one-cycle pulse; the stop bit was sampled low.
- `OVERRUN` out 1: one-cycle pulse; a complete byte was dropped because the FIFO was full.

## Operation
- **Synchronizer.** `RXD` passes through 2 flops (both reset to 1), producing `rx_s`. All logic uses `rx_s` only.
- **Bit counter.** `cnt` is `$clog2(CLKS_PER_BIT)` bits wide and clears on every state change. `bit_idx` is 3 bits and counts data bits.
- **FSM states:**
  - IDLE: when `rx_s==0`, go to START.
  - START: at `cnt==HALF-1`, sample `rx_s`. If 1, it is a glitch: go to IDLE with no output. If 0, go to DATA with `bit_idx=0`.
  - DATA: at `cnt==CLKS_PER_BIT-1`, shift `rx_s` into the shift register at bit `bit_idx`. After bit 7, go to STOP.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx_s`.
    - If 1, push the byte and go to IDLE. Leaving at mid-stop-bit allows back-to-back frames.
    - If 0, pulse `FRAME_ERR`, discard the byte and go to BREAK.
  - BREAK: wait until `rx_s==1`, then go to IDLE. A held-low line (break) never produces bytes.
- **FIFO behaviour:**
  - A push while full drops the new byte and pulses `OVERRUN`. FIFO contents are unchanged.
  - A push and pop in the same cycle while full: the pop frees an entry, the push is accepted and there is no `OVERRUN`.
  - A push and pop in the same cycle while empty: the push is accepted. `VALID` rises the next cycle; the pop is ignored because `VALID` was 0.
  - Pointers wrap modulo `FIFO_DEPTH`. The count ranges from 0 to `FIFO_DEPTH`.
- `READY` has no effect when `VALID=0`. `DATA` is stable while `VALID && !READY`.

## Timing
- **Reset values:** `DATA=0`, `VALID=0`, `FRAME_ERR=0`, `OVERRUN=0`. FSM=IDLE, FIFO empty, synchronizer=1.
- **Reset mid-frame:** the partial byte and all FIFO contents are lost.
- **Reference cycle:** let `t` be the first cycle in which `rx_s==0` in IDLE. `t` is 2 clocks after `RXD` is first captured low.
- **Sample points:**
  - Start bit: cycle `t+HALF`.
  - Data bit `i`: cycle `t+HALF+(i+1)·CLKS_PER_BIT`.
  - Stop bit: cycle `t+HALF+9·CLKS_PER_BIT`.
- **Latency:** the push occurs in the stop-sample cycle. `VALID` and `DATA` are registered and are seen 1 cycle later; `FRAME_ERR` and `OVERRUN` pulse in that same following cycle.
- **Pop:** on the edge where `VALID && READY`, the next entry (or empty) appears after that edge. Zero-bubble streaming is possible.
- **Glitch rejection:** a low pulse shorter than `HALF` cycles on `rx_s` is rejected.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - `UART_DATA_BITS=8`;
  - the default `CLKS_PER_BIT`.
- The `TXD` transmitter imports the same package.
- Sub-module `uart_rx_fifo` is a synchronous FIFO with push/pop, full/empty and registered head output, parameterized by depth and width.
- The FSM, synchronizer and shift register stay in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `FIFO_DEPTH=4`.
- **Single byte:** send 0x55 8N1 with `READY=0`. `VALID=1`, `DATA=0x55` rises exactly `HALF+9·16+1` cycles after `rx_s` falls and holds. Raise `READY` for 1 cycle: `VALID` drops next cycle.
- **Glitch:** drive a low pulse of 6 cycles on `RXD`. No `VALID`, no `FRAME_ERR`, FSM back in IDLE. A following 0xC3 is received correctly.
- **Framing error and break:** send 0xA3 with the stop bit low, hold the line low for 3 bit times, then release. Exactly one `FRAME_ERR` pulse, no `VALID`. A subsequent 0x3C is received as 0x3C.
- **Overrun:** with `READY=0`, send 0x01..0x05 back-to-back. One `OVERRUN` pulse at the 5th stop sample. Draining yields 0x01, 0x02, 0x03, 0x04, then `VALID=0`.
- **Simultaneous push/pop:** with the FIFO full and `READY=1` exactly in the push cycle. No `OVERRUN`; the drain order is preserved with the new byte last.
- **Reset mid-frame:** assert `RST` low during data bit 4, with 2 bytes buffered. All outputs are 0 immediately and the FIFO is empty. After release, 0xF0 is received correctly.
